// File: rtl/exec_pkg.sv
// exec_pkg: micro-op encodings, condition codes and flag bit positions for the execute result stage
package exec_pkg;
    typedef enum logic [4:0] {
        UOP_NOP = 5'b00000,
        UOP_CMP = 5'b00101
    } uop_e;
    typedef enum logic [3:0] {
        COND_EQ, COND_NE, COND_CS, COND_CC, COND_MI, COND_PL, COND_VS, COND_VC,
        COND_HI, COND_LS, COND_GE, COND_LT, COND_GT, COND_LE, COND_AL, COND_NV
    } cond_e;
    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 3;
endpackage

// File: rtl/exec_result_stage_if.sv
// exec_result_stage_if: ALU-result input handshake and register-file writeback handshake
interface exec_result_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_result;
    logic [3:0]  in_flags;
    logic [4:0]  in_uop;
    logic [3:0]  in_rd;
    logic        in_setflags;
    logic [3:0]  in_cond;
    logic        wb_valid;
    logic        wb_ready;
    logic [31:0] wb_data;
    logic [3:0]  wb_rd;
    modport master (
        output in_valid, in_result, in_flags, in_uop, in_rd, in_setflags, in_cond, wb_ready,
        input  in_ready, wb_valid, wb_data, wb_rd
    );
    modport slave (
        input  in_valid, in_result, in_flags, in_uop, in_rd, in_setflags, in_cond, wb_ready,
        output in_ready, wb_valid, wb_data, wb_rd
    );
endinterface

// File: rtl/exec_result_stage_cond_eval.sv
// cond_eval: combinational ARM condition-code check against NZCV flags
module cond_eval
    import exec_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);
    logic z, c, n, v;
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign n = flags[FLAG_N];
    assign v = flags[FLAG_V];
    always_comb begin
        pass = 1'b0;
        case (cond_e'(cond))
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c && !z;
            COND_LS: pass = !c || z;
            COND_GE: pass = n == v;
            COND_LT: pass = n != v;
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = z || (n != v);
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end
endmodule

// File: rtl/exec_result_stage.sv
// exec_result_stage: conditional retire, NZCV commit and writeback FIFO after the ALU
module exec_result_stage
    import exec_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    exec_result_stage_if.slave   bus,
    output logic [3:0]           flags_q,
    output logic [CNT_W-1:0]     retired_cnt,
    output logic [CNT_W-1:0]     squashed_cnt
);
    localparam int AW = $clog2(DEPTH);
    logic [31:0]   data_mem [DEPTH];
    logic [3:0]    rd_mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0]   count;
    logic          pass, is_cmp, accept, push, pop;
    cond_eval u_cond (
        .cond  (bus.in_cond),
        .flags (flags_q),
        .pass  (pass)
    );
    assign is_cmp       = bus.in_uop == UOP_CMP;
    assign bus.in_ready = !rst && count < (AW+1)'(DEPTH);
    assign accept       = bus.in_valid && bus.in_ready;
    assign push         = accept && pass && !is_cmp && bus.in_uop != UOP_NOP;
    assign pop          = bus.wb_valid && bus.wb_ready;
    assign bus.wb_valid = count != '0;
    assign bus.wb_data  = data_mem[rp];
    assign bus.wb_rd    = rd_mem[rp];
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wp] <= bus.in_result;
            rd_mem[wp]   <= bus.in_rd;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wp           <= '0;
            rp           <= '0;
            count        <= '0;
            flags_q      <= '0;
            retired_cnt  <= '0;
            squashed_cnt <= '0;
        end else begin
            if (push) wp <= wp + AW'(1);
            if (pop) rp <= rp + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
            if (accept && pass) retired_cnt <= retired_cnt + CNT_W'(1);
            if (accept && !pass) squashed_cnt <= squashed_cnt + CNT_W'(1);
            if (accept && pass && (bus.in_setflags || is_cmp)) flags_q <= bus.in_flags;
        end
    end
endmodule

// File: tb/tb_exec_result_stage.sv
// tb_exec_result_stage: directed self-checking bench for exec_result_stage
module tb_exec_result_stage;
    import exec_pkg::*;
    localparam logic [4:0] ADD = 5'b00001;
    localparam logic [4:0] MOV = 5'b00010;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  flags_q;
    logic [15:0] retired_cnt, squashed_cnt;
    int checks = 0;
    int failures = 0;
    exec_result_stage_if bus ();
    exec_result_stage #(.DEPTH(2), .CNT_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus.slave),
        .flags_q      (flags_q),
        .retired_cnt  (retired_cnt),
        .squashed_cnt (squashed_cnt)
    );
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] res, input logic [3:0] fl, input logic [4:0] uop,
                         input logic [3:0] rd, input logic sf, input logic [3:0] cond);
        bus.in_valid    = 1'b1;
        bus.in_result   = res;
        bus.in_flags    = fl;
        bus.in_uop      = uop;
        bus.in_rd       = rd;
        bus.in_setflags = sf;
        bus.in_cond     = cond;
    endtask

    task automatic send(input logic [31:0] res, input logic [3:0] fl, input logic [4:0] uop,
                        input logic [3:0] rd, input logic sf, input logic [3:0] cond);
        drive(res, fl, uop, rd, sf, cond);
        tick();
        bus.in_valid = 1'b0;
    endtask

    // ARM-style: even code selects a base test, odd code inverts it; AL/NV special
    function automatic logic exp_pass(input logic [3:0] c, input logic [3:0] f);
        logic z, cy, n, v, b;
        z = f[0]; cy = f[1]; n = f[2]; v = f[3];
        case (c[3:1])
            3'd0: b = z;
            3'd1: b = cy;
            3'd2: b = n;
            3'd3: b = v;
            3'd4: b = cy & ~z;
            3'd5: b = n ~^ v;
            3'd6: b = ~z & (n ~^ v);
            default: b = 1'b1;
        endcase
        return (c == 4'hF) ? 1'b0 : (c == 4'hE) ? 1'b1 : b ^ c[0];
    endfunction

    task automatic test_reset;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.wb_ready = 1'b0;
        drive(0, 0, UOP_NOP, 0, 0, 0);
        bus.in_valid = 1'b0;
        tick(); tick();
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready_low got=%b exp=0", bus.in_ready); end
        rst = 1'b0;
        tick();
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready_high got=%b exp=1", bus.in_ready); end
        checks++; if (flags_q !== 4'b0000) begin failures++; $display("FAIL reset_flags got=%b exp=0000", flags_q); end
        checks++; if (bus.wb_valid !== 1'b0) begin failures++; $display("FAIL reset_wb_valid got=%b exp=0", bus.wb_valid); end
        checks++; if (retired_cnt !== 16'd0 || squashed_cnt !== 16'd0) begin failures++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", retired_cnt, squashed_cnt); end
    endtask

    task automatic test_cmp_al;
        send(32'd0, 4'b0011, UOP_CMP, 4'd0, 1'b0, COND_AL);
        checks++; if (flags_q !== 4'b0011) begin failures++; $display("FAIL cmp_flags got=%b exp=0011", flags_q); end
        checks++; if (bus.wb_valid !== 1'b0) begin failures++; $display("FAIL cmp_no_wb got=%b exp=0", bus.wb_valid); end
        checks++; if (retired_cnt !== 16'd1) begin failures++; $display("FAIL cmp_retired got=%0d exp=1", retired_cnt); end
    endtask

    task automatic test_cond_eq;
        send(32'd7, 4'b0000, ADD, 4'd3, 1'b0, COND_EQ);
        checks++; if (bus.wb_valid !== 1'b1) begin failures++; $display("FAIL eq_wb_valid got=%b exp=1", bus.wb_valid); end
        checks++; if (bus.wb_data !== 32'd7 || bus.wb_rd !== 4'd3) begin failures++; $display("FAIL eq_wb got=%0d/%0d exp=7/3", bus.wb_data, bus.wb_rd); end
        checks++; if (retired_cnt !== 16'd2) begin failures++; $display("FAIL eq_retired got=%0d exp=2", retired_cnt); end
        bus.wb_ready = 1'b1;
        tick();
        bus.wb_ready = 1'b0;
        checks++; if (bus.wb_valid !== 1'b0) begin failures++; $display("FAIL eq_pop got=%b exp=0", bus.wb_valid); end
        send(32'd9, 4'b1100, ADD, 4'd4, 1'b1, COND_NE);
        checks++; if (squashed_cnt !== 16'd1) begin failures++; $display("FAIL ne_squashed got=%0d exp=1", squashed_cnt); end
        checks++; if (bus.wb_valid !== 1'b0) begin failures++; $display("FAIL ne_no_push got=%b exp=0", bus.wb_valid); end
        checks++; if (flags_q !== 4'b0011) begin failures++; $display("FAIL ne_flags_held got=%b exp=0011", flags_q); end
    endtask

    task automatic test_back_to_back;
        drive(32'd0, 4'b0000, UOP_CMP, 4'd0, 1'b0, COND_AL);
        tick();
        drive(32'd5, 4'b0000, ADD, 4'd5, 1'b0, COND_EQ);
        tick();
        bus.in_valid = 1'b0;
        checks++; if (flags_q !== 4'b0000) begin failures++; $display("FAIL b2b_flags got=%b exp=0000", flags_q); end
        checks++; if (squashed_cnt !== 16'd2) begin failures++; $display("FAIL b2b_squashed got=%0d exp=2", squashed_cnt); end
        checks++; if (bus.wb_valid !== 1'b0) begin failures++; $display("FAIL b2b_no_push got=%b exp=0", bus.wb_valid); end
        checks++; if (retired_cnt !== 16'd3) begin failures++; $display("FAIL b2b_retired got=%0d exp=3", retired_cnt); end
    endtask

    task automatic test_full;
        bus.wb_ready = 1'b0;
        send(32'd11, 4'b0000, MOV, 4'd1, 1'b0, COND_AL);
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL full_ready_one got=%b exp=1", bus.in_ready); end
        send(32'd22, 4'b0000, MOV, 4'd2, 1'b0, COND_AL);
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL full_ready_two got=%b exp=0", bus.in_ready); end
        drive(32'd33, 4'b0000, MOV, 4'd3, 1'b0, COND_AL);
        tick();
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL full_held got=%b exp=0", bus.in_ready); end
        checks++; if (bus.wb_rd !== 4'd1 || bus.wb_data !== 32'd11) begin failures++; $display("FAIL full_stable got=%0d/%0d exp=1/11", bus.wb_rd, bus.wb_data); end
        checks++; if (retired_cnt !== 16'd5) begin failures++; $display("FAIL full_retired got=%0d exp=5", retired_cnt); end
        bus.wb_ready = 1'b1;
        tick();
        bus.wb_ready = 1'b0;
        checks++; if (bus.wb_rd !== 4'd2 || bus.in_ready !== 1'b1) begin failures++; $display("FAIL full_pop_only got=rd%0d/rdy%b exp=rd2/rdy1", bus.wb_rd, bus.in_ready); end
        checks++; if (retired_cnt !== 16'd5) begin failures++; $display("FAIL full_no_accept got=%0d exp=5", retired_cnt); end
        tick();
        bus.in_valid = 1'b0;
        checks++; if (bus.in_ready !== 1'b0 || retired_cnt !== 16'd6) begin failures++; $display("FAIL full_refill got=rdy%b/ret%0d exp=rdy0/ret6", bus.in_ready, retired_cnt); end
        checks++; if (bus.wb_rd !== 4'd2) begin failures++; $display("FAIL full_head2 got=%0d exp=2", bus.wb_rd); end
        bus.wb_ready = 1'b1;
        tick();
        checks++; if (bus.wb_rd !== 4'd3 || bus.wb_data !== 32'd33) begin failures++; $display("FAIL full_head3 got=%0d/%0d exp=3/33", bus.wb_rd, bus.wb_data); end
        tick();
        bus.wb_ready = 1'b0;
        checks++; if (bus.wb_valid !== 1'b0) begin failures++; $display("FAIL full_drained got=%b exp=0", bus.wb_valid); end
    endtask

    task automatic test_reset_mid;
        send(32'd44, 4'b1111, MOV, 4'd4, 1'b1, COND_AL);
        send(32'd55, 4'b0000, MOV, 4'd5, 1'b0, COND_AL);
        checks++; if (flags_q !== 4'b1111 || bus.wb_valid !== 1'b1 || bus.in_ready !== 1'b0) begin failures++; $display("FAIL mid_setup got=%b/%b/%b exp=1111/1/0", flags_q, bus.wb_valid, bus.in_ready); end
        rst = 1'b1;
        bus.wb_ready = 1'b1;
        drive(32'd66, 4'b1010, MOV, 4'd6, 1'b1, COND_AL);
        tick();
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL mid_ready_low got=%b exp=0", bus.in_ready); end
        checks++; if (bus.wb_valid !== 1'b0 || flags_q !== 4'b0000) begin failures++; $display("FAIL mid_cleared got=%b/%b exp=0/0000", bus.wb_valid, flags_q); end
        checks++; if (retired_cnt !== 16'd0 || squashed_cnt !== 16'd0) begin failures++; $display("FAIL mid_cnt got=%0d/%0d exp=0/0", retired_cnt, squashed_cnt); end
        rst = 1'b0;
        bus.in_valid = 1'b0;
        bus.wb_ready = 1'b0;
        tick();
        checks++; if (bus.in_ready !== 1'b1 || bus.wb_valid !== 1'b0) begin failures++; $display("FAIL mid_after got=rdy%b/v%b exp=rdy1/v0", bus.in_ready, bus.wb_valid); end
    endtask

    task automatic test_cond_table;
        int exp_r = 0;
        int exp_s = 0;
        logic p;
        bus.wb_ready = 1'b1;
        for (int f = 0; f < 16; f++) begin
            for (int c = 0; c < 16; c++) begin
                send(32'd0, 4'(f), UOP_CMP, 4'd0, 1'b0, COND_AL);
                exp_r++;
                p = exp_pass(4'(c), 4'(f));
                send(32'(c), 4'(~f), ADD, 4'(c), 1'b0, 4'(c));
                if (p) exp_r++; else exp_s++;
                checks++; if (squashed_cnt !== 16'(exp_s) || retired_cnt !== 16'(exp_r)) begin failures++; $display("FAIL cond_cnt c=%h f=%b got=%0d/%0d exp=%0d/%0d", c, f, retired_cnt, squashed_cnt, exp_r, exp_s); end
                checks++; if (bus.wb_valid !== p) begin failures++; $display("FAIL cond_push c=%h f=%b got=%b exp=%b", c, f, bus.wb_valid, p); end
                checks++; if (flags_q !== 4'(f)) begin failures++; $display("FAIL cond_flags c=%h f=%b got=%b", c, f, flags_q); end
            end
        end
        tick();
        bus.wb_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_cmp_al();
        test_cond_eq();
        test_back_to_back();
        test_full();
        test_reset_mid();
        test_cond_table();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
